// File: rtl/scene_fade_mux.sv
// scene_fade_mux: selects one of NUM_SCENES renderer address/RGB streams and
// applies a frame-synchronous fade-to-black / fade-in on every scene change.
// Optional feature macro: SCENE_FADE_SKIP_EN adds a 'skip' input that cuts
// straight to the requested scene on a frame_start, bypassing the fade.
//
// state    | meaning
// IDLE     | steady: showing active_scene at its settled level
// FADE_OUT | stepping fade_level down towards 0 before switching scene
// FADE_IN  | stepping fade_level up towards LMAX after a switch
module scene_fade_mux #(
    parameter int NUM_SCENES      = 4,
    parameter int SCENE_ID_W      = 4,
    parameter int ADDR_W          = 17,
    parameter int RGB_W           = 12,
    parameter int FADE_STEPS_LOG2 = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SCENE_ID_W-1:0]        scene_state,
    input  logic                         frame_start,
    input  logic                         valid,
`ifdef SCENE_FADE_SKIP_EN
    input  logic                         skip,
`endif
    input  logic [NUM_SCENES*RGB_W-1:0]  scene_rgb_flat,
    input  logic [NUM_SCENES*ADDR_W-1:0] scene_addr_flat,
    output logic [ADDR_W-1:0]            pixel_addr_out,
    output logic [RGB_W-1:0]             rgb_out,
    output logic [SCENE_ID_W-1:0]        active_scene,
    output logic                         fading,
    output logic [FADE_STEPS_LOG2-1:0]   fade_level
);

    localparam logic [FADE_STEPS_LOG2-1:0] LMAX = '1;
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int PW = 4 + FADE_STEPS_LOG2;

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

    state_t                       state_q;
    logic [SCENE_ID_W-1:0]        active_q;
    logic [SCENE_ID_W-1:0]        target_q;
    logic [SCENE_ID_W-1:0]        target_d;
    logic [FADE_STEPS_LOG2-1:0]   level_q;
    logic [SW-1:0]                step_cnt_q;
    logic [RGB_W-1:0]             rgb_q;
    logic [RGB_W-1:0]             rgb_d;
    logic [RGB_W-1:0]             pix_sel;
    logic [ADDR_W-1:0]            addr_sel;
    logic [PW-1:0]                prod;
    logic                         scene_ok;
    logic                         step_evt;

    // Requested scene as seen this cycle: freshly sampled on frame_start, else held.
    always_comb begin
        scene_ok = (scene_state != '0) && (scene_state <= SCENE_ID_W'(NUM_SCENES));
        target_d = target_q;
        if (frame_start) begin
            target_d = scene_ok ? scene_state : '0;
        end
        step_evt = frame_start && (step_cnt_q == SW'(FRAMES_PER_STEP - 1));
    end

    // Fade sequencer: target capture, step counter, level and displayed scene.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            active_q   <= '0;
            target_q   <= '0;
            level_q    <= '0;
            step_cnt_q <= '0;
        end else begin
            if (frame_start) begin
                target_q   <= target_d;
                step_cnt_q <= step_evt ? '0 : step_cnt_q + 1'b1;
            end
`ifdef SCENE_FADE_SKIP_EN
            if (frame_start && skip) begin
                active_q   <= target_d;
                state_q    <= IDLE;
                level_q    <= (target_d == '0) ? '0 : LMAX;
                step_cnt_q <= '0;
            end else
`endif
            begin
                case (state_q)
                    IDLE: begin
                        if (frame_start && target_d != active_q) begin
                            step_cnt_q <= '0;
                            if (level_q == '0) begin
                                active_q <= target_d;
                                if (target_d != '0) state_q <= FADE_IN;
                            end else begin
                                state_q <= FADE_OUT;
                            end
                        end
                    end
                    FADE_OUT: begin
                        // A step from level 0 (aborted fade-in at its first level) just completes.
                        if (step_evt) begin
                            if (level_q <= FADE_STEPS_LOG2'(1)) begin
                                level_q    <= '0;
                                active_q   <= target_d;
                                step_cnt_q <= '0;
                                state_q    <= (target_d != '0) ? FADE_IN : IDLE;
                            end else begin
                                level_q <= level_q - 1'b1;
                            end
                        end
                    end
                    FADE_IN: begin
                        if (frame_start && target_d != active_q) begin
                            state_q    <= FADE_OUT;
                            step_cnt_q <= '0;
                        end else if (step_evt) begin
                            if (level_q >= LMAX - 1'b1) begin
                                level_q    <= LMAX;
                                state_q    <= IDLE;
                                step_cnt_q <= '0;
                            end else begin
                                level_q <= level_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Channel mux driven by the displayed scene; scene 0 selects nothing (black / address 0).
    always_comb begin
        pix_sel  = '0;
        addr_sel = '0;
        for (int i = 0; i < NUM_SCENES; i++) begin
            if (active_q == SCENE_ID_W'(i + 1)) begin
                pix_sel  = scene_rgb_flat[i*RGB_W +: RGB_W];
                addr_sel = scene_addr_flat[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Per-4-bit-channel scaling by fade_level; full level passes the pixel untouched.
    always_comb begin
        rgb_d = '0;
        prod  = '0;
        if (valid && active_q != '0) begin
            if (level_q == LMAX) begin
                rgb_d = pix_sel;
            end else begin
                for (int j = 0; j < RGB_W / 4; j++) begin
                    prod = PW'(pix_sel[j*4 +: 4]) * PW'(level_q);
                    rgb_d[j*4 +: 4] = prod[FADE_STEPS_LOG2 +: 4];
                end
            end
        end
    end

    // Output pixel register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rgb_q <= '0;
        else      rgb_q <= rgb_d;
    end

    assign pixel_addr_out = addr_sel;
    assign rgb_out        = rgb_q;
    assign active_scene   = active_q;
    assign fading         = (state_q != IDLE);
    assign fade_level     = level_q;

endmodule

// File: tb/tb_scene_fade_mux.sv
// Directed bench: small instance (LMAX=3, one frame per step) for the
// behavioural walk-through, default instance for the 30-frame fade timing.
module tb_scene_fade_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  scene_state = 4'd1;
    logic        frame_start = 1'b0;
    logic        valid = 1'b1;
`ifdef SCENE_FADE_SKIP_EN
    logic        skip = 1'b0;
`endif
    logic [47:0] scene_rgb_flat  = {12'hFFF, 12'h00F, 12'h0F0, 12'hF84};
    logic [67:0] scene_addr_flat = {17'h01D44, 17'h00C33, 17'h00B22, 17'h00A11};

    logic [16:0] s_addr, d_addr;
    logic [11:0] s_rgb, d_rgb;
    logic [3:0]  s_act, d_act;
    logic        s_fad, d_fad;
    logic [1:0]  s_lvl;
    logic [3:0]  d_lvl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scene_fade_mux #(.FADE_STEPS_LOG2(2), .FRAMES_PER_STEP(1)) dut_s (
        .clk(clk), .rst(rst), .scene_state(scene_state), .frame_start(frame_start),
        .valid(valid),
`ifdef SCENE_FADE_SKIP_EN
        .skip(skip),
`endif
        .scene_rgb_flat(scene_rgb_flat), .scene_addr_flat(scene_addr_flat),
        .pixel_addr_out(s_addr), .rgb_out(s_rgb), .active_scene(s_act),
        .fading(s_fad), .fade_level(s_lvl)
    );

    scene_fade_mux dut_d (
        .clk(clk), .rst(rst), .scene_state(scene_state), .frame_start(frame_start),
        .valid(valid),
`ifdef SCENE_FADE_SKIP_EN
        .skip(skip),
`endif
        .scene_rgb_flat(scene_rgb_flat), .scene_addr_flat(scene_addr_flat),
        .pixel_addr_out(d_addr), .rgb_out(d_rgb), .active_scene(d_act),
        .fading(d_fad), .fade_level(d_lvl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        // Reset held low
        repeat (3) tick();
        chk("rst_rgb", s_rgb, 12'h000);
        chk("rst_act", s_act, 4'd0);
        chk("rst_lvl", s_lvl, 2'd0);
        chk("rst_fad", s_fad, 1'b0);
        chk("rst_addr", s_addr, 17'h0);
        @(negedge clk);
        rst = 1'b1;

        // Power-up fade-in to scene 1
        frame();
        chk("t1_act", s_act, 4'd1);
        chk("t1_fad", s_fad, 1'b1);
        chk("t1_lvl0", s_lvl, 2'd0);
        chk("t1_addr", s_addr, 17'h00A11);
        frame();
        chk("t1_lvl1", s_lvl, 2'd1);
        frame();
        chk("t1_lvl2", s_lvl, 2'd2);
        tick();
        chk("t3_rgb_l2", s_rgb, 12'h742);
        @(negedge clk);
        valid = 1'b0;
        tick();
        chk("t3_rgb_blank", s_rgb, 12'h000);
        valid = 1'b1;
        frame();
        chk("t1_lvl3", s_lvl, 2'd3);
        chk("t1_idle", s_fad, 1'b0);
        tick();
        chk("t3_rgb_full", s_rgb, 12'hF84);

        // Scene 1 -> 3; no switch without frame_start
        scene_state = 4'd3;
        repeat (4) tick();
        chk("t2_hold_act", s_act, 4'd1);
        chk("t2_hold_fad", s_fad, 1'b0);
        frame();
        chk("t2_k_fad", s_fad, 1'b1);
        chk("t2_k_lvl", s_lvl, 2'd3);
        frame();
        chk("t2_k1_lvl", s_lvl, 2'd2);
        frame();
        chk("t2_k2_lvl", s_lvl, 2'd1);
        chk("t2_k2_act", s_act, 4'd1);
        frame();
        chk("t2_k3_lvl", s_lvl, 2'd0);
        chk("t2_k3_act", s_act, 4'd3);
        chk("t2_k3_addr", s_addr, 17'h00C33);
        frame();
        chk("t2_k4_lvl", s_lvl, 2'd1);
        frame();
        chk("t2_k5_lvl", s_lvl, 2'd2);
        tick();
        chk("t2_rgb_l2", s_rgb, 12'h007);
        frame();
        chk("t2_k6_lvl", s_lvl, 2'd3);
        chk("t2_k6_idle", s_fad, 1'b0);

        // Redirect mid fade-in
        scene_state = 4'd4;
        frames(4);
        chk("t4_act4", s_act, 4'd4);
        frame();
        chk("t4_lvl1", s_lvl, 2'd1);
        scene_state = 4'd2;
        frame();
        chk("t4_out_lvl", s_lvl, 2'd1);
        chk("t4_out_act", s_act, 4'd4);
        chk("t4_out_fad", s_fad, 1'b1);
        frame();
        chk("t4_sw_lvl", s_lvl, 2'd0);
        chk("t4_sw_act", s_act, 4'd2);
        chk("t4_sw_addr", s_addr, 17'h00B22);
        frames(3);
        chk("t4_done_lvl", s_lvl, 2'd3);

        // Fade to black, then invalid scene id maps to black
        scene_state = 4'd0;
        frames(4);
        chk("t5_act", s_act, 4'd0);
        chk("t5_lvl", s_lvl, 2'd0);
        chk("t5_fad", s_fad, 1'b0);
        tick();
        chk("t5_rgb", s_rgb, 12'h000);
        scene_state = 4'd9;
        frame();
        chk("t5_inv_act", s_act, 4'd0);
        chk("t5_inv_fad", s_fad, 1'b0);

        // Default parameters: 30 frames in, 30 frames out
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        scene_state = 4'd4;
        frame();
        chk("d_in_act", d_act, 4'd4);
        chk("d_in_lvl0", d_lvl, 4'd0);
        chk("d_in_addr", d_addr, 17'h01D44);
        frames(29);
        chk("d_in_lvl14", d_lvl, 4'd14);
        chk("d_in_fad14", d_fad, 1'b1);
        tick();
        chk("d_rgb_l14", d_rgb, 12'hDDD);
        frame();
        chk("d_in_lvl15", d_lvl, 4'd15);
        chk("d_in_idle", d_fad, 1'b0);
        tick();
        chk("d_rgb_full", d_rgb, 12'hFFF);
        scene_state = 4'd0;
        frame();
        chk("d_out_fad", d_fad, 1'b1);
        chk("d_out_lvl15", d_lvl, 4'd15);
        frames(29);
        chk("d_out_lvl1", d_lvl, 4'd1);
        chk("d_out_act4", d_act, 4'd4);
        frame();
        chk("d_out_lvl0", d_lvl, 4'd0);
        chk("d_out_act0", d_act, 4'd0);
        chk("d_out_idle", d_fad, 1'b0);
        tick();
        chk("d_out_rgb", d_rgb, 12'h000);

        // Reset mid fade-out
        scene_state = 4'd2;
        frames(4);
        chk("t6_pre_lvl", s_lvl, 2'd3);
        scene_state = 4'd1;
        frames(2);
        chk("t6_mid_fad", s_fad, 1'b1);
        chk("t6_mid_lvl", s_lvl, 2'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_fad", s_fad, 1'b0);
        chk("t6_rst_act", s_act, 4'd0);
        chk("t6_rst_lvl", s_lvl, 2'd0);
        chk("t6_rst_rgb", s_rgb, 12'h000);
        @(negedge clk);
        rst = 1'b1;

`ifdef SCENE_FADE_SKIP_EN
        scene_state = 4'd3;
        skip = 1'b1;
        frame();
        skip = 1'b0;
        chk("sk_act", s_act, 4'd3);
        chk("sk_lvl", s_lvl, 2'd3);
        chk("sk_fad", s_fad, 1'b0);
        scene_state = 4'd1;
        frames(2);
        chk("sk_mid_lvl", s_lvl, 2'd2);
        @(negedge clk);
        skip = 1'b1;
        repeat (2) tick();
        chk("sk_noframe", s_fad, 1'b1);
        scene_state = 4'd2;
        frame();
        skip = 1'b0;
        chk("sk2_act", s_act, 4'd2);
        chk("sk2_lvl", s_lvl, 2'd3);
        chk("sk2_fad", s_fad, 1'b0);
        chk("sk2_addr", s_addr, 17'h00B22);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
